// File: rtl/pr_vec_reader.sv
`default_nettype none
// ============================================================================
//  Module      : pr_vec_reader
//  Description : Streaming reader for a PageRank rank vector. Fetches one word
//                at a time and presents it on a val/rdy stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module pr_vec_reader #(
    parameter int NBITS      = 32,
    parameter int ADDR_NBITS = 16,
    parameter int CNT_NBITS  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_NBITS-1:0] base_addr,
    input  logic [CNT_NBITS-1:0]  num_nodes,
    output logic                  mem_req_val,
    input  logic                  mem_req_rdy,
    output logic [ADDR_NBITS-1:0] mem_req_addr,
    input  logic                  mem_resp_val,
    input  logic [NBITS-1:0]      mem_resp_data,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [NBITS-1:0]      out_data,
    output logic [CNT_NBITS-1:0]  out_idx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_NBITS-1:0] c_one = CNT_NBITS'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_NBITS-1:0]   r_base;
    logic [CNT_NBITS-1:0]    r_num;
    logic [CNT_NBITS-1:0]    r_idx;
    logic [NBITS-1:0]        r_data;
    logic                    w_start;
    logic                    w_cap;
    logic                    w_adv;
    logic                    w_last;
    logic [ADDR_NBITS-1:0]   w_idx_ext;

    // Index and address widths are independent; fit the index to the address.
    if (CNT_NBITS >= ADDR_NBITS) begin : g_idx_trunc
        assign w_idx_ext = r_idx[ADDR_NBITS-1:0];
    end else begin : g_idx_zext
        assign w_idx_ext = {{(ADDR_NBITS-CNT_NBITS){1'b0}}, r_idx};
    end

    // Comparing against num-1 keeps num = 2^CNT_NBITS-1 free of idx overflow.
    assign w_last = (r_idx == (r_num - c_one));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base <= '0;
            r_num  <= '0;
        end else if (w_start) begin
            r_base <= base_addr;
            r_num  <= num_nodes;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_start) begin
            r_idx <= '0;
        end else if (w_adv) begin
            r_idx <= r_idx + c_one;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_cap) begin
            r_data <= mem_resp_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cap       = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_start     = 1'b1;
                    w_state_nxt = (num_nodes == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_rdy) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_val) begin
                    w_cap       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (out_rdy) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_adv       = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_req_val  = (r_state == S_REQ);
    assign mem_req_addr = r_base + w_idx_ext;
    assign out_val      = (r_state == S_SEND);
    assign out_data     = r_data;
    assign out_idx      = r_idx;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pr_vec_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pr_vec_reader
//  Description : Self-checking bench for pr_vec_reader with a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pr_vec_reader;

    localparam int NB = 32;
    localparam int AB = 16;
    localparam int CB = 16;

    logic          clk;
    logic          reset;
    logic          go;
    logic [AB-1:0] base_addr;
    logic [CB-1:0] num_nodes;
    logic          mem_req_val;
    logic          mem_req_rdy;
    logic [AB-1:0] mem_req_addr;
    logic          mem_resp_val;
    logic [NB-1:0] mem_resp_data;
    logic          out_val;
    logic          out_rdy;
    logic [NB-1:0] out_data;
    logic [CB-1:0] out_idx;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] base;
        logic [15:0] num;
        int          stall_min;
        int          stall_max;
        int          lat_max;
        int          rdy_pct;
        int          exp_cycles;
        bit          noise;
        logic [31:0] salt;
    } xfer_t;

    pr_vec_reader #(
        .NBITS      (NB),
        .ADDR_NBITS (AB),
        .CNT_NBITS  (CB)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .base_addr     (base_addr),
        .num_nodes     (num_nodes),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_data (mem_resp_data),
        .out_val       (out_val),
        .out_rdy       (out_rdy),
        .out_data      (out_data),
        .out_idx       (out_idx),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: a function of the address only, optionally salted.
    function automatic logic [31:0] mem_word(input logic [15:0] a, input logic [31:0] salt);
        return ({16'h0, a} << 1) ^ salt;
    endfunction

    // Runs one transfer from a sample point (posedge+1) with the DUT idle.
    // Expected stream: word i = mem_word(base+i mod 2^16), idx i, for i < num.
    task automatic run_xfer(input xfer_t v, input string tag);
        int          req_n, out_n, cd, stall_cnt, stall_tgt, budget;
        bit          pending, exp_done, prev_oval, prev_ordy, finished;
        logic [15:0] pend_addr, a;
        base_addr = v.base;
        num_nodes = v.num;
        go        = 1'b1;
        @(posedge clk); #1;
        go        = 1'b0;
        req_n = 0; out_n = 0; cd = 0; stall_cnt = 0;
        stall_tgt = $urandom_range(v.stall_max, v.stall_min);
        pending = 0; exp_done = (v.num == 16'd0); prev_oval = 0; prev_ordy = 0; finished = 0;
        pend_addr = '0;
        budget = 200 + int'(v.num) * (v.stall_max + v.lat_max + 40);
        for (int c = 0; c < budget; c++) begin
            check({tag, " busy"}, 64'(busy), 64'(1'b1));
            check({tag, " done"}, 64'(done), 64'(exp_done));
            if (done !== exp_done) break;
            if (exp_done) begin
                if (v.exp_cycles >= 0) check({tag, " go-to-done cycles"}, 64'(c), 64'(v.exp_cycles));
                check({tag, " words out"}, 64'(out_n), 64'(v.num));
                finished = 1;
                break;
            end
            if (mem_req_val === 1'b1) begin
                check({tag, " single outstanding"}, 64'(pending), 64'(1'b0));
                check({tag, " no extra request"}, 64'(req_n < int'(v.num)), 64'(1'b1));
                a = v.base + 16'(req_n);
                check({tag, " req addr"}, 64'(mem_req_addr), 64'(a));
            end
            if (prev_oval && !prev_ordy) check({tag, " out_val held"}, 64'(out_val), 64'(1'b1));
            if (out_val === 1'b1) begin
                a = v.base + 16'(out_n);
                check({tag, " out_idx"}, 64'(out_idx), 64'(out_n));
                check({tag, " out_data"}, 64'(out_data), 64'(mem_word(a, v.salt)));
            end
            prev_oval = (out_val === 1'b1);
            // memory response side
            mem_resp_val  = 1'b0;
            mem_resp_data = $urandom;
            if (pending) begin
                if (cd <= 1) begin
                    mem_resp_val  = 1'b1;
                    mem_resp_data = mem_word(pend_addr, v.salt);
                    pending       = 0;
                end else begin
                    cd--;
                end
            end else if (v.noise && $urandom_range(3, 0) == 0) begin
                mem_resp_val = 1'b1;
            end
            // memory request side
            if (mem_req_val === 1'b1) begin
                if (stall_cnt >= stall_tgt) begin
                    mem_req_rdy = 1'b1;
                    pend_addr   = v.base + 16'(req_n);
                    req_n++;
                    pending     = 1;
                    cd          = $urandom_range(v.lat_max, 1);
                    stall_cnt   = 0;
                    stall_tgt   = $urandom_range(v.stall_max, v.stall_min);
                end else begin
                    mem_req_rdy = 1'b0;
                    stall_cnt++;
                end
            end else begin
                mem_req_rdy = 1'($urandom_range(1, 0));
            end
            // consumer side
            out_rdy = ($urandom_range(99, 0) < v.rdy_pct);
            if (out_val === 1'b1 && out_rdy) begin
                out_n++;
                if (out_n == int'(v.num)) exp_done = 1;
            end
            prev_ordy = out_rdy;
            // go pulses while busy must be ignored
            go = 1'b0;
            if (v.noise && $urandom_range(3, 0) == 0) begin
                go        = 1'b1;
                base_addr = 16'($urandom);
                num_nodes = 16'($urandom_range(5, 0));
            end
            @(posedge clk); #1;
        end
        check({tag, " completed"}, 64'(finished), 64'(1'b1));
        go = 1'b0; mem_req_rdy = 1'b0; out_rdy = 1'b0; mem_resp_val = 1'b0;
        @(posedge clk); #1;
        check({tag, " idle after done"}, 64'({busy, done}), 64'(2'b00));
        if (!finished) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_req_val"}, 64'(mem_req_val), 64'(1'b0));
        check({tag, " mem_req_addr"}, 64'(mem_req_addr), 64'(0));
        check({tag, " out_val"}, 64'(out_val), 64'(1'b0));
        check({tag, " out_data"}, 64'(out_data), 64'(0));
        check({tag, " out_idx"}, 64'(out_idx), 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(1'b0));
        check({tag, " done"}, 64'(done), 64'(1'b0));
    endtask

    xfer_t tbl[6];
    xfer_t rv;

    initial begin
        reset = 1'b1; go = 1'b0; base_addr = '0; num_nodes = '0;
        mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0; out_rdy = 1'b0;

        //          base      num    smin smax lat rdy  cyc noise salt
        tbl[0] = '{16'h0010, 16'd4, 0,   0,   1,  100, 12, 1'b0, 32'h0};
        tbl[1] = '{16'h0055, 16'd0, 0,   0,   1,  100, 0,  1'b0, 32'h0};
        tbl[2] = '{16'h0200, 16'd6, 5,   5,   3,  50,  -1, 1'b0, 32'h1357_9BDF};
        tbl[3] = '{16'hFFFE, 16'd3, 0,   1,   2,  70,  -1, 1'b0, 32'h0};
        tbl[4] = '{16'h1234, 16'd5, 0,   2,   4,  60,  -1, 1'b1, 32'hCAFE_0000};
        tbl[5] = '{16'h7000, 16'd1, 0,   0,   1,  100, 3,  1'b0, 32'h0BAD_F00D};

        @(posedge clk); #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i], $sformatf("vec%0d", i));
        end

        // Async reset while waiting for a response; the late response must be dropped.
        base_addr = 16'h0300; num_nodes = 16'd3; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; mem_req_rdy = 1'b1;
        @(posedge clk); #1;
        mem_req_rdy = 1'b0;
        check("midwait busy", 64'(busy), 64'(1'b1));
        check("midwait no req", 64'(mem_req_val), 64'(1'b0));
        #3 reset = 1'b1;
        #1 check_all_zero("async reset");
        @(posedge clk); #2;
        reset = 1'b0;
        mem_resp_val = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_resp_val = 1'b0;
        check_all_zero("late resp");
        rv = '{16'h0040, 16'd2, 0, 0, 1, 100, 6, 1'b0, 32'h0};
        run_xfer(rv, "post-reset");

        for (int i = 0; i < 25; i++) begin
            rv.base       = 16'($urandom);
            rv.num        = 16'($urandom_range(10, 0));
            rv.stall_min  = 0;
            rv.stall_max  = $urandom_range(3, 0);
            rv.lat_max    = $urandom_range(4, 1);
            rv.rdy_pct    = $urandom_range(100, 30);
            rv.exp_cycles = -1;
            rv.noise      = 1'b1;
            rv.salt       = $urandom;
            run_xfer(rv, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
